// File: rtl/bcd_serial_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bcd_serial_alu
//  Purpose  : Multi-digit packed-BCD adder/subtractor. One decimal digit is
//             processed per clock, least-significant digit first, with the
//             +6/-6 decimal correction applied inline. A start/busy/done
//             handshake runs one operation at a time. Flags use the CPU
//             {Z, N, H, C} layout so they can be written back to F.
//  Ports    : i_clk, i_rst (async, active high)
//             i_start, i_sub, i_carry_in, i_a, i_b   request + operands
//             o_busy, o_done                         handshake
//             o_result, o_flags, o_invalid           registered results
//  Revision : 1.0  initial release
// ============================================================================
module bcd_serial_alu #(
   parameter int DIGITS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_sub,
   input  logic                  i_carry_in,
   input  logic [4*DIGITS-1:0]   i_a,
   input  logic [4*DIGITS-1:0]   i_b,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_result,
   output logic [3:0]            o_flags,
   output logic                  o_invalid
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q,   state_d;
   logic [IW-1:0]   idx_q,     idx_d;
   logic [W-1:0]    a_q,       a_d;
   logic [W-1:0]    b_q,       b_d;
   logic            sub_q,     sub_d;
   logic            carry_q,   carry_d;
   logic [W-1:0]    result_q,  result_d;
   logic [3:0]      flags_q,   flags_d;
   logic            invalid_q, invalid_d;
   logic            busy_q,    busy_d;
   logic            done_q,    done_d;

   // Digit datapath: current operand digits and one corrected BCD digit step
   logic [W-1:0]    a_shift, b_shift;
   logic [3:0]      a_dig, b_dig;
   logic [4:0]      sum5, diff5;
   logic [3:0]      dig_out;
   logic            dig_cout;
   logic            dig_bad;

   always_comb begin
      a_shift  = a_q >> {idx_q, 2'b00};
      b_shift  = b_q >> {idx_q, 2'b00};
      a_dig    = a_shift[3:0];
      b_dig    = b_shift[3:0];
      sum5     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
      // Two's-complement 5-bit difference; range -16..15, so bit 4 is the sign
      diff5    = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, carry_q};
      dig_bad  = (a_dig > 4'd9) || (b_dig > 4'd9);
      dig_out  = sum5[3:0];
      dig_cout = 1'b0;
      if (sub_q) begin
         if (diff5[4]) begin
            dig_out  = diff5[3:0] - 4'd6;
            dig_cout = 1'b1;
         end else begin
            dig_out  = diff5[3:0];
            dig_cout = 1'b0;
         end
      end else if (sum5 > 5'd9) begin
         dig_out  = sum5[3:0] + 4'd6;
         dig_cout = 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      sub_d     = sub_q;
      carry_d   = carry_q;
      result_d  = result_q;
      flags_d   = flags_q;
      invalid_d = invalid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d   = S_RUN;
               idx_d     = '0;
               a_d       = i_a;
               b_d       = i_b;
               sub_d     = i_sub;
               carry_d   = i_carry_in;
               result_d  = '0;
               invalid_d = 1'b0;
               busy_d    = 1'b1;
            end
         end
         S_RUN: begin
            // Result was cleared at accept, so each digit slot is written once
            result_d  = result_q | (W'(dig_out) << {idx_q, 2'b00});
            carry_d   = dig_cout;
            invalid_d = invalid_q | dig_bad;
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               idx_d   = '0;
               done_d  = 1'b1;
               // Z must include the digit being written on this same edge
               flags_d = {(result_d == '0), sub_q, 1'b0, dig_cout};
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         carry_q   <= 1'b0;
         result_q  <= '0;
         flags_q   <= 4'b0000;
         invalid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sub_q     <= sub_d;
         carry_q   <= carry_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         invalid_q <= invalid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_result  = result_q;
   assign o_flags   = flags_q;
   assign o_invalid = invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_serial_alu
//  Purpose  : Scoreboard bench for bcd_serial_alu at DIGITS = 4, 1 and 16.
//             The driver pushes the expected response for each accepted
//             request; per-instance monitors pop and compare on o_done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_serial_alu;

   typedef struct packed {
      logic [31:0] acc;     // cycle count at the accept edge
      logic [63:0] res;
      logic [3:0]  flags;
      logic        inv;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   // Instance 0: DIGITS=4, instance 1: DIGITS=1, instance 2: DIGITS=16
   logic        start0, sub0, cin0, busy0, done0, inv0;
   logic [15:0] a0, b0, res0;
   logic [3:0]  flags0;
   logic        start1, sub1, cin1, busy1, done1, inv1;
   logic [3:0]  a1, b1, res1;
   logic [3:0]  flags1;
   logic        start2, sub2, cin2, busy2, done2, inv2;
   logic [63:0] a2, b2, res2;
   logic [3:0]  flags2;

   bcd_serial_alu #(.DIGITS(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_start(start0), .i_sub(sub0), .i_carry_in(cin0),
      .i_a(a0), .i_b(b0), .o_busy(busy0), .o_done(done0), .o_result(res0),
      .o_flags(flags0), .o_invalid(inv0));

   bcd_serial_alu #(.DIGITS(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start1), .i_sub(sub1), .i_carry_in(cin1),
      .i_a(a1), .i_b(b1), .o_busy(busy1), .o_done(done1), .o_result(res1),
      .o_flags(flags1), .o_invalid(inv1));

   bcd_serial_alu #(.DIGITS(16)) u_dut16 (
      .i_clk(clk), .i_rst(rst), .i_start(start2), .i_sub(sub2), .i_carry_in(cin2),
      .i_a(a2), .i_b(b2), .o_busy(busy2), .o_done(done2), .o_result(res2),
      .o_flags(flags2), .o_invalid(inv2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- decimal reference model ----------------
   function automatic int ndig(input int w);
      return (w == 0) ? 4 : (w == 1) ? 1 : 16;
   endfunction

   function automatic longint unsigned bcd2int(input logic [63:0] v, input int d);
      longint unsigned r = 0;
      for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [63:0] int2bcd(input longint unsigned n, input int d);
      logic [63:0] r = '0;
      longint unsigned t = n;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic exp_t model(input int d, input logic sub, input logic cin,
                                  input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      longint unsigned p = 1;
      longint unsigned av, bv, r, t;
      logic c;
      for (int i = 0; i < d; i++) p = p * 10;
      av = bcd2int(a, d);
      bv = bcd2int(b, d);
      if (!sub) begin
         t = av + bv + longint'(cin);
         c = (t >= p);
         r = c ? t - p : t;
      end else if (av >= bv + longint'(cin)) begin
         r = av - bv - longint'(cin);
         c = 1'b0;
      end else begin
         r = p + av - bv - longint'(cin);
         c = 1'b1;
      end
      e.acc   = '0;
      e.res   = int2bcd(r, d);
      e.flags = {(r == 0), sub, 1'b0, c};
      e.inv   = 1'b0;
      return e;
   endfunction

   function automatic logic [63:0] rand_bcd(input int d);
      logic [63:0] v = '0;
      for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   // ---------------- checking ----------------
   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic mon(input int w, input logic [63:0] r, input logic [3:0] f, input logic inv);
      exp_t e;
      int   sz;
      sz = (w == 0) ? q0.size() : (w == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_done inst%0d: got done with empty scoreboard required no done", w);
      end else begin
         case (w)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         cmp($sformatf("result inst%0d", w), r, e.res);
         cmp($sformatf("flags inst%0d", w), {60'd0, f}, {60'd0, e.flags});
         cmp($sformatf("invalid inst%0d", w), {63'd0, inv}, {63'd0, e.inv});
         // o_done is seen in the cycle after edge accept+DIGITS
         cmp($sformatf("latency inst%0d", w), 64'(cyc - e.acc), 64'(ndig(w)));
      end
   endtask

   always @(negedge clk) if (done0 === 1'b1) mon(0, {48'd0, res0}, flags0, inv0);
   always @(negedge clk) if (done1 === 1'b1) mon(1, {60'd0, res1}, flags1, inv1);
   always @(negedge clk) if (done2 === 1'b1) mon(2, res2, flags2, inv2);

   // ---------------- stimulus ----------------
   function automatic logic get_busy(input int w);
      return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
   endfunction

   task automatic drive(input int w, input logic st, input logic sb, input logic ci,
                        input logic [63:0] a, input logic [63:0] b);
      case (w)
         0: begin start0 = st; sub0 = sb; cin0 = ci; a0 = a[15:0]; b0 = b[15:0]; end
         1: begin start1 = st; sub1 = sb; cin1 = ci; a1 = a[3:0];  b1 = b[3:0];  end
         default: begin start2 = st; sub2 = sb; cin2 = ci; a2 = a; b2 = b; end
      endcase
   endtask

   task automatic wait_idle(input int w);
      int n = 0;
      while (get_busy(w) !== 1'b0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         checks++;
         errors++;
         $display("FAIL timeout inst%0d: busy stuck high, required idle", w);
      end
   endtask

   // Issue one request; poke=1 also pulses i_start with other operands mid-run
   task automatic issue(input int w, input logic sb, input logic ci,
                        input logic [63:0] a, input logic [63:0] b,
                        input exp_t e, input logic poke);
      exp_t ee = e;
      wait_idle(w);
      @(negedge clk);
      drive(w, 1'b1, sb, ci, a, b);
      ee.acc = cyc + 1;
      case (w)
         0:       q0.push_back(ee);
         1:       q1.push_back(ee);
         default: q2.push_back(ee);
      endcase
      @(negedge clk);
      // operands are free to change once accepted
      drive(w, 1'b0, ~sb, ~ci, ~a, 64'h5555_5555_5555_5555);
      if (poke) begin
         @(negedge clk);
         drive(w, 1'b1, 1'b0, 1'b1, 64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999);
         @(negedge clk);
         drive(w, 1'b0, 1'b0, 1'b0, '0, '0);
      end
      wait_idle(w);
   endtask

   task automatic op(input int w, input logic sb, input logic ci,
                     input logic [63:0] a, input logic [63:0] b);
      issue(w, sb, ci, a, b, model(ndig(w), sb, ci, a, b), 1'b0);
   endtask

   task automatic op_hand(input int w, input logic sb, input logic ci,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] r, input logic [3:0] f,
                          input logic inv, input logic poke);
      exp_t e;
      e.acc = '0; e.res = r; e.flags = f; e.inv = inv;
      issue(w, sb, ci, a, b, e, poke);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(2, 1'b0, 1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      cmp("reset busy",    {63'd0, busy0}, 64'd0);
      cmp("reset done",    {63'd0, done0}, 64'd0);
      cmp("reset result",  {48'd0, res0},  64'd0);
      cmp("reset flags",   {60'd0, flags0}, 64'd0);
      cmp("reset invalid", {63'd0, inv0},  64'd0);
      rst = 1'b0;
      @(negedge clk);

      // DIGITS=4 directed vectors with hand-computed results
      op_hand(0, 1'b0, 1'b0, 64'h1234, 64'h8766, 64'h0000, 4'b1001, 1'b0, 1'b0);
      op_hand(0, 1'b0, 1'b0, 64'h0950, 64'h0050, 64'h1000, 4'b0000, 1'b0, 1'b0);
      op_hand(0, 1'b0, 1'b1, 64'h0999, 64'h0000, 64'h1000, 4'b0000, 1'b0, 1'b0);
      op_hand(0, 1'b1, 1'b0, 64'h5000, 64'h1234, 64'h3766, 4'b0100, 1'b0, 1'b0);
      op_hand(0, 1'b1, 1'b0, 64'h0000, 64'h0001, 64'h9999, 4'b0101, 1'b0, 1'b0);
      op_hand(0, 1'b1, 1'b0, 64'h4321, 64'h4321, 64'h0000, 4'b1100, 1'b0, 1'b0);
      op_hand(0, 1'b1, 1'b1, 64'h1000, 64'h0000, 64'h0999, 4'b0100, 1'b0, 1'b0);
      op_hand(0, 1'b0, 1'b0, 64'h9999, 64'h0001, 64'h0000, 4'b1001, 1'b0, 1'b0);
      // Invalid digit 0xA: corrected to 0 with carry into the hundreds digit.
      // A start pulse during RUN must be ignored (monitor flags any extra done).
      op_hand(0, 1'b0, 1'b0, 64'h00A0, 64'h0000, 64'h0100, 4'b0000, 1'b1, 1'b1);

      // Reset on the second RUN cycle: no done, outputs back to reset values
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b0, 64'h1234, 64'h1111);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      cmp("midrst busy",   {63'd0, busy0},  64'd0);
      cmp("midrst result", {48'd0, res0},   64'd0);
      cmp("midrst flags",  {60'd0, flags0}, 64'd0);
      cmp("midrst done",   {63'd0, done0},  64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      op_hand(0, 1'b0, 1'b0, 64'h2468, 64'h1357, 64'h3825, 4'b0000, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_bcd(4), rand_bcd(4));

      // DIGITS=1
      op_hand(1, 1'b0, 1'b0, 64'h9, 64'h1, 64'h0, 4'b1001, 1'b0, 1'b0);
      op_hand(1, 1'b1, 1'b0, 64'h3, 64'h7, 64'h6, 4'b0101, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) op(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_bcd(1), rand_bcd(1));

      // DIGITS=16
      op_hand(2, 1'b0, 1'b0, 64'h9999_9999_9999_9999, 64'h1, 64'h0, 4'b1001, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) op(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_bcd(16), rand_bcd(16));

      repeat (10) @(negedge clk);
      cmp("scoreboard empty inst0", 64'(q0.size()), 64'd0);
      cmp("scoreboard empty inst1", 64'(q1.size()), 64'd0);
      cmp("scoreboard empty inst2", 64'(q2.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
